// File: rtl/lifo_cmd_initiator.sv
// ---------------------------------------------------------------------------
// lifo_cmd_initiator
//   Initiator side of the stack-memory push/pop interface. Takes byte-level
//   push/pop requests from a host (valid/ready), sequences them onto the
//   stack's push/pop/wdata lines using the stack's two-phase timing, and
//   returns popped bytes on a one-cycle response strobe. Occupancy is tracked
//   here so overflow/underflow never reaches the memory.
//
//   Optional build macro: LIFO_ERR_STICKY_EN
//     defined   : err is sticky, cleared by err_clr (a coincident set wins)
//     undefined : err is a 1-cycle pulse per illegal op, err_clr is ignored
//
// Ports
//   clk, reset          clock, async active-high reset (shared with stack)
//   req_valid/req_ready host request handshake
//   req_pop, req_data   1 = pop / 0 = push, byte to push
//   rsp_valid, rsp_data popped-byte strobe, last popped byte (held)
//   err, err_clr        illegal-operation flag, sticky clear
//   count, full, empty  occupancy
//   stk_push, stk_pop,  stack command lines and write data
//   stk_wdata
//   stk_rdata           stack read data
// ---------------------------------------------------------------------------
module lifo_cmd_initiator #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_pop,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              err,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_wdata,
  input  logic [DATA_W-1:0] stk_rdata
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PUSH_A  = 3'd1;
  localparam logic [2:0] S_PUSH_B  = 3'd2;
  localparam logic [2:0] S_POP_A   = 3'd3;
  localparam logic [2:0] S_POP_B   = 3'd4;
  localparam logic [2:0] S_POP_CAP = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              phase_q, phase_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              err_q, err_d;

  logic full_w, empty_w, accept, illegal;

  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

  // Accept only in IDLE on phase 1 so the command's first cycle lands on
  // the stack's phase 0. The cycle carrying rsp_valid is skipped so a pop
  // response never overlaps a new accept.
  assign req_ready = (state_q == S_IDLE) && phase_q && !rsp_valid_q;
  assign accept    = req_valid && req_ready;
  // Illegal ops are still accepted (host never stalls) but go nowhere.
  assign illegal   = accept && (req_pop ? empty_w : full_w);

  always_comb begin
    state_d     = state_q;
    phase_d     = ~phase_q;
    count_d     = count_q;
    wdata_d     = wdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && !illegal) begin
          if (req_pop) begin
            state_d = S_POP_A;
          end else begin
            state_d = S_PUSH_A;
            wdata_d = req_data;
          end
        end
      end
      S_PUSH_A:  state_d = S_PUSH_B;
      S_PUSH_B: begin
        state_d = S_IDLE;
        count_d = count_q + CNT_W'(1);
      end
      S_POP_A:   state_d = S_POP_B;
      S_POP_B:   state_d = S_POP_CAP;
      S_POP_CAP: begin
        // stack read data is valid in this cycle only
        state_d     = S_IDLE;
        rsp_data_d  = stk_rdata;
        rsp_valid_d = 1'b1;
        count_d     = count_q - CNT_W'(1);
      end
      default:   state_d = S_IDLE;
    endcase
  end

`ifdef LIFO_ERR_STICKY_EN
  always_comb begin
    err_d = illegal | (err_q & ~err_clr);
  end
`else
  logic err_clr_unused;
  assign err_clr_unused = err_clr;
  always_comb begin
    err_d = illegal;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      count_q     <= '0;
      wdata_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      count_q     <= count_d;
      wdata_q     <= wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
    end
  end

  // Command lines decode straight from state, so reset clears them at once.
  assign stk_push  = (state_q == S_PUSH_A) || (state_q == S_PUSH_B);
  assign stk_pop   = (state_q == S_POP_A)  || (state_q == S_POP_B);
  assign stk_wdata = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;
  assign count     = count_q;
  assign full      = full_w;
  assign empty     = empty_w;

  a_push_pop_excl: assert property (@(posedge clk) disable iff (reset)
    !(stk_push && stk_pop));
  a_wdata_stable: assert property (@(posedge clk) disable iff (reset)
    (state_q == S_PUSH_B) |-> $stable(wdata_q));
  a_count_range: assert property (@(posedge clk) disable iff (reset)
    count_q <= CNT_W'(DEPTH));

endmodule
